// File: rtl/usb_bitstuff_nrzi.sv
// USB full-speed transmit line encoder: bit stuffing, NRZI encoding and EOP generation.
// The upstream serializer shifts on the same edge that sees take high.
module usb_bitstuff_nrzi #(
  parameter int unsigned STUFF_LEN = 6,
  parameter int unsigned EOP_SE0   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_en,
  input  logic start,
  input  logic s_in,
  input  logic last,
  output logic take,
  output logic dp,
  output logic dm,
  output logic oe,
  output logic busy,
  output logic done
);

  localparam int unsigned OnesW = $clog2(STUFF_LEN + 1);
  localparam int unsigned EopW  = $clog2(EOP_SE0 + 1);

  typedef enum logic [2:0] {StIdle, StSend, StStuff, StEops, StEopj} state_e;

  state_e           state_q, state_d;
  logic [OnesW-1:0] ones_q, ones_d, ones_inc;
  logic [EopW-1:0]  eop_q, eop_d;
  logic             last_seen_q, last_seen_d;
  logic             dp_q, dp_d, dm_q, dm_d, oe_q, oe_d, done_q, done_d;
  logic             consume;

  always_comb begin
    state_d     = state_q;
    ones_d      = ones_q;
    eop_d       = eop_q;
    last_seen_d = last_seen_q;
    dp_d        = dp_q;
    dm_d        = dm_q;
    oe_d        = oe_q;
    done_d      = 1'b0;
    consume     = 1'b0;
    ones_inc    = s_in ? ones_q + OnesW'(1) : '0;

    if (bit_en) begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            oe_d    = 1'b1;
            consume = 1'b1;
          end else begin
            dp_d   = 1'b1;
            dm_d   = 1'b0;
            oe_d   = 1'b0;
            ones_d = '0;
          end
        end
        StSend: consume = 1'b1;
        StStuff: begin
          dp_d    = ~dp_q;
          dm_d    = ~dm_q;
          ones_d  = '0;
          state_d = last_seen_q ? StEops : StSend;
        end
        StEops: begin
          dp_d = 1'b0;
          dm_d = 1'b0;
          if (eop_q == EopW'(EOP_SE0 - 1)) begin
            eop_d   = '0;
            state_d = StEopj;
          end else begin
            eop_d = eop_q + EopW'(1);
          end
        end
        StEopj: begin
          // eop_q marks whether the J bit time has already been launched
          if (eop_q == '0) begin
            dp_d  = 1'b1;
            dm_d  = 1'b0;
            eop_d = EopW'(1);
          end else begin
            oe_d    = 1'b0;
            done_d  = 1'b1;
            eop_d   = '0;
            ones_d  = '0;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (consume) begin
      ones_d = ones_inc;
      if (!s_in) begin
        dp_d = ~dp_q;
        dm_d = ~dm_q;
      end
      if (ones_inc == OnesW'(STUFF_LEN)) begin
        state_d     = StStuff;
        last_seen_d = last;
      end else if (last) begin
        state_d = StEops;
      end else begin
        state_d = StSend;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ones_q      <= '0;
      eop_q       <= '0;
      last_seen_q <= 1'b0;
      dp_q        <= 1'b1;
      dm_q        <= 1'b0;
      oe_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ones_q      <= ones_d;
      eop_q       <= eop_d;
      last_seen_q <= last_seen_d;
      dp_q        <= dp_d;
      dm_q        <= dm_d;
      oe_q        <= oe_d;
      done_q      <= done_d;
    end
  end

  assign take = bit_en & ~rst & (((state_q == StIdle) & start) | (state_q == StSend));
  assign busy = (state_q != StIdle);
  assign dp   = dp_q;
  assign dm   = dm_q;
  assign oe   = oe_q;
  assign done = done_q;

endmodule

// File: tb/tb_usb_bitstuff_nrzi.sv
// Bench for usb_bitstuff_nrzi: packets are expanded into an expected per-bit-time line
// schedule by a plain-arithmetic model, then driven with optional bit_en gaps.
module tb_usb_bitstuff_nrzi;

  localparam int StuffLen = 6;
  localparam int EopSe0   = 2;

  logic clk = 1'b0;
  logic rst, bit_en, start, s_in, last;
  logic take, dp, dm, oe, busy, done;

  always #5 clk = ~clk;

  usb_bitstuff_nrzi #(.STUFF_LEN(StuffLen), .EOP_SE0(EopSe0)) dut (
    .clk(clk), .rst(rst), .bit_en(bit_en), .start(start), .s_in(s_in), .last(last),
    .take(take), .dp(dp), .dm(dm), .oe(oe), .busy(busy), .done(done)
  );

  typedef struct {bit take; bit dp; bit dm; bit oe; bit busy; bit done;} slot_t;

  slot_t exp_q[$];
  bit    pkt[$];
  int    vectors = 0;
  int    miscompares = 0;
  bit    e_dp, e_dm, e_oe, e_busy, e_done;
  string cur;

  // Expected line schedule: one entry per bit_en cycle from start through done.
  task automatic build();
    bit lvl = 1'b1;
    int ones = 0;
    exp_q.delete();
    foreach (pkt[i]) begin
      if (!pkt[i]) lvl = ~lvl;
      ones = pkt[i] ? ones + 1 : 0;
      exp_q.push_back('{1'b1, lvl, ~lvl, 1'b1, 1'b1, 1'b0});
      if (ones == StuffLen) begin
        lvl  = ~lvl;
        ones = 0;
        exp_q.push_back('{1'b0, lvl, ~lvl, 1'b1, 1'b1, 1'b0});
      end
    end
    for (int k = 0; k < EopSe0; k++) exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    exp_q.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
    exp_q.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
  endtask

  task automatic cycle(input bit be, input bit st, input bit si, input bit la, input slot_t nx);
    @(negedge clk);
    vectors++;
    if ({dp, dm} !== {e_dp, e_dm}) begin
      miscompares++;
      $display("FAIL %s line: got dp/dm=%b%b want %b%b @%0t", cur, dp, dm, e_dp, e_dm, $time);
    end
    vectors++;
    if ({oe, busy, done} !== {e_oe, e_busy, e_done}) begin
      miscompares++;
      $display("FAIL %s oe/busy/done: got %b%b%b want %b%b%b @%0t", cur, oe, busy, done,
               e_oe, e_busy, e_done, $time);
    end
    rst = 1'b0; bit_en = be; start = st; s_in = si; last = la;
    #1;
    vectors++;
    if (take !== (be & nx.take)) begin
      miscompares++;
      $display("FAIL %s take: got %b want %b @%0t", cur, take, be & nx.take, $time);
    end
    if (be) {e_dp, e_dm, e_oe, e_busy, e_done} = {nx.dp, nx.dm, nx.oe, nx.busy, nx.done};
    else e_done = 1'b0;
  endtask

  task automatic reset_cycle();
    @(negedge clk);
    vectors++;
    if ({dp, dm, oe, busy, done} !== {e_dp, e_dm, e_oe, e_busy, e_done}) begin
      miscompares++;
      $display("FAIL %s pre-reset outputs: got %b%b%b%b%b want %b%b%b%b%b", cur, dp, dm, oe,
               busy, done, e_dp, e_dm, e_oe, e_busy, e_done);
    end
    rst = 1'b1; bit_en = 1'b1; start = 1'b1;
    s_in = 1'($urandom_range(0, 1)); last = 1'($urandom_range(0, 1));
    #1;
    vectors++;
    if (take !== 1'b0) begin
      miscompares++;
      $display("FAIL %s take during reset: got %b want 0", cur, take);
    end
    {e_dp, e_dm, e_oe, e_busy, e_done} = 5'b10000;
  endtask

  task automatic run_packet(input bit gapped, input int abort_at);
    int    idx = 0;
    slot_t idle_s = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    build();
    for (int i = 0; i < exp_q.size(); i++) begin
      bit si, la, st;
      if (gapped) begin
        int g = 3 + int'($urandom_range(0, 2));
        for (int k = 0; k < g; k++)
          cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), idle_s);
      end
      if (i == abort_at) begin
        reset_cycle();
        return;
      end
      st = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (exp_q[i].take) begin
        si = pkt[idx];
        la = (idx == pkt.size() - 1);
        idx++;
      end else begin
        si = 1'($urandom_range(0, 1));
        la = 1'($urandom_range(0, 1));
      end
      cycle(1'b1, st, si, la, exp_q[i]);
    end
    cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), idle_s);
  endtask

  task automatic set_pkt(input bit [63:0] bits, input int n);
    pkt.delete();
    for (int i = 0; i < n; i++) pkt.push_back(bits[i]);
  endtask

  task automatic test_reset();
    cur = "reset";
    rst = 1'b1; bit_en = 1'b1; start = 1'b1; s_in = 1'b1; last = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({dp, dm, oe, busy, done} !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset outputs: got dp dm oe busy done=%b%b%b%b%b want 10000",
               dp, dm, oe, busy, done);
    end
    rst = 1'b0; start = 1'b0;
    #1;
    vectors++;
    if (take !== 1'b0) begin
      miscompares++;
      $display("FAIL reset take idle: got %b want 0", take);
    end
    {e_dp, e_dm, e_oe, e_busy, e_done} = 5'b10000;
  endtask

  task automatic test_sync();
    cur = "sync";
    set_pkt(64'h080, 9);
    run_packet(1'b0, -1);
  endtask

  task automatic test_stuff_mid();
    cur = "stuff_mid";
    set_pkt(64'h7f, 8);
    run_packet(1'b0, -1);
  endtask

  task automatic test_stuff_last();
    cur = "stuff_last";
    set_pkt(64'h3f, 6);
    run_packet(1'b0, -1);
  endtask

  task automatic test_gapped();
    cur = "gapped";
    set_pkt(64'h7f, 8);
    run_packet(1'b1, -1);
  endtask

  task automatic test_single_bit();
    cur = "single_bit";
    for (int r = 0; r < 2; r++) begin
      set_pkt(64'(r), 1);
      run_packet(1'b0, -1);
    end
  endtask

  task automatic test_random();
    cur = "random";
    for (int r = 0; r < 20; r++) begin
      int n = int'($urandom_range(1, 40));
      pkt.delete();
      for (int i = 0; i < n; i++) pkt.push_back($urandom_range(0, 3) != 0);
      run_packet(1'($urandom_range(0, 1)), -1);
    end
  endtask

  task automatic test_reset_mid();
    cur = "reset_mid_send";
    set_pkt(64'hff, 8);
    run_packet(1'b0, 4);
    cur = "after_reset_send";
    set_pkt(64'h07, 4);
    run_packet(1'b0, -1);
    cur = "reset_mid_eops";
    set_pkt(64'h2, 3);
    run_packet(1'b0, 4);
    cur = "after_reset_eops";
    set_pkt(64'h0f, 5);
    run_packet(1'b1, -1);
  endtask

  initial begin
    test_reset();
    test_sync();
    test_stuff_mid();
    test_stuff_last();
    test_gapped();
    test_single_bit();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
